// File: rtl/rv32i_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// slave is the LSU's view; master is the combined core + memory view.
interface rv32i_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rd_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ack, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_addr, mem_wr_data, mem_wr_ena, mem_be
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ack, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_addr, mem_wr_data, mem_wr_ena, mem_be
  );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: byte/half/word lane steering, load extension,
// alignment and funct3 checking, and a bounded wait for the memory ack.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rst,
  rv32i_lsu_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrAlign   = 2'b01;
  localparam logic [1:0] ErrFunct3  = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [1:0]  resp_err_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wr_data_q;
  logic        mem_wr_ena_q;
  logic [3:0]  mem_be_q;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Request decode, evaluated on the incoming request while idle.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = bus.req_wdata;
    if (bus.req_store) begin
      illegal = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3[2] & bus.req_funct3[1]);
    end
    unique case (bus.req_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << bus.req_addr[1:0];
        wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = bus.req_addr[0];
        be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (bus.req_addr[1:0] != 2'b00);
        be         = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    lane = bus.mem_rd_data >> {off_q, 3'b000};
    unique case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_data = bus.mem_rd_data;
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      off_q         <= 2'b00;
      funct3_q      <= 3'b000;
      store_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_err_q    <= ErrNone;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wr_data_q <= 32'd0;
      mem_wr_ena_q  <= 1'b0;
      mem_be_q      <= 4'b0000;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            off_q    <= bus.req_addr[1:0];
            funct3_q <= bus.req_funct3;
            store_q  <= bus.req_store;
            if (illegal || misaligned) begin
              // funct3 legality outranks alignment.
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'd0;
              resp_err_q   <= illegal ? ErrFunct3 : ErrAlign;
            end else begin
              state_q       <= StBusy;
              cnt_q         <= 8'd0;
              mem_req_q     <= 1'b1;
              mem_addr_q    <= {bus.req_addr[31:2], 2'b00};
              mem_be_q      <= be;
              mem_wr_data_q <= wdata;
              mem_wr_ena_q  <= bus.req_store;
            end
          end
        end
        StBusy: begin
          // An ack on the terminal-count cycle still completes normally.
          if (bus.mem_ack) begin
            state_q      <= StResp;
            mem_req_q    <= 1'b0;
            mem_wr_ena_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ErrNone;
            resp_rdata_q <= store_q ? 32'd0 : load_data;
          end else if (cnt_q == TimeoutLast) begin
            state_q      <= StResp;
            mem_req_q    <= 1'b0;
            mem_wr_ena_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ErrTimeout;
            resp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_wr_ena  = mem_wr_ena_q;
  assign bus.mem_be      = mem_be_q;

endmodule
